// File: rtl/scan_decoder_pkg.sv
// Shared constants for the scan/decode one-hot driver: controller state
// encoding and the meaning of the mode input.
package scan_decoder_pkg;

  // Controller states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  // Values of the mode input
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational N-to-2^N one-hot decoder. Exactly one output bit is set,
// the one addressed by idx; masking to all-zero is left to the caller.
module onehot_decode #(
  parameter int N = 3
) (
  input  logic [N-1:0]      idx,
  output logic [2**N-1:0]   y
);

  // Set the single bit addressed by idx
  always_comb begin
    y      = '0;
    y[idx] = 1'b1;
  end

endmodule : onehot_decode

// File: rtl/scan_decoder.sv
// One-hot row/digit select driver. In decode mode it latches sel on load;
// in scan mode it walks all 2^N outputs, holding each for DWELL cycles and
// pulsing wrap when the walk rolls back to output 0. All outputs are flops.
module scan_decoder #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      idx,
  output logic              valid,
  output logic              wrap
);

  import scan_decoder_pkg::*;

  localparam int OUTS  = 2**N;
  // A DWELL of 1 still gets a one-bit counter so the compare stays legal
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [N-1:0]     IDX_LAST = '1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N-1:0]     idx_nxt;
  logic             valid_nxt;
  logic             wrap_nxt;
  logic [OUTS-1:0]  dec_y;

  // Next-state, index, dwell counter and wrap; enable outranks mode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    idx_nxt   = idx;
    valid_nxt = valid;
    wrap_nxt  = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
    end else if (mode == MODE_DECODE) begin
      state_nxt = DECODE;
      if (load) begin
        idx_nxt   = sel;
        valid_nxt = 1'b1;
      end else if (state != DECODE) begin
        // Arriving from IDLE or SCAN with nothing to latch: go dark
        idx_nxt   = '0;
        valid_nxt = 1'b0;
      end
    end else begin
      state_nxt = SCAN;
      valid_nxt = 1'b1;
      if (state != SCAN) begin
        // Fresh scan always starts at output 0 with a full dwell
        idx_nxt = '0;
      end else if (cnt == CNT_LAST) begin
        idx_nxt  = idx + 1'b1;
        wrap_nxt = (idx == IDX_LAST);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  onehot_decode #(.N(N)) u_onehot_decode (
    .idx (idx_nxt),
    .y   (dec_y)
  );

  // Register every output; Y is forced dark whenever it is not valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      Y     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      valid <= valid_nxt;
      wrap  <= wrap_nxt;
      Y     <= valid_nxt ? dec_y : '0;
    end
  end

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: N=3/DWELL=4 main instance plus an
// N=2/DWELL=1 instance, followed by a randomized run against a small model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] Y;
  logic [2:0] idx;
  logic       valid, wrap;

  logic       enable2 = 1'b0, mode2 = 1'b0, load2 = 1'b0;
  logic [1:0] sel2 = '0;
  logic [3:0] Y2;
  logic [1:0] idx2;
  logic       valid2, wrap2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_decoder #(.N(3), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .sel(sel), .Y(Y), .idx(idx), .valid(valid), .wrap(wrap)
  );

  scan_decoder #(.N(2), .DWELL(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .mode(mode2), .load(load2),
    .sel(sel2), .Y(Y2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] scan_exp  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] scan2_exp [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  // reference model state for the random phase
  int   m_ph, m_idx, m_cnt, rand_bad;
  bit   m_valid, m_wrap;
  logic [7:0] m_y;

  initial begin
    // ---- reset state
    step(); step();
    chk("rst_y", Y, 0); chk("rst_idx", idx, 0); chk("rst_valid", valid, 0); chk("rst_wrap", wrap, 0);
    reset = 1'b0;

    // ---- decode sweep
    enable = 1'b1; mode = 1'b0; load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      chk($sformatf("dec_y_%0d", i), Y, sweep_exp[i]);
      chk($sformatf("dec_idx_%0d", i), idx, i);
      chk($sformatf("dec_valid_%0d", i), valid, 1);
    end
    load = 1'b0; sel = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dec_hold_y", Y, 8'h80);
    end

    // ---- scan from decode: 70 cycles, wrap at 33 and 65
    mode = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      step();
      chk($sformatf("scan_y_c%0d", c), Y, scan_exp[((c - 1) / 4) % 8]);
      chk($sformatf("scan_wrap_c%0d", c), wrap, (c == 33 || c == 65) ? 1 : 0);
      chk($sformatf("scan_valid_c%0d", c), valid, 1);
      chk($sformatf("scan_idx_c%0d", c), idx, ((c - 1) / 4) % 8);
    end

    // ---- enable drop mid-dwell, then restart with full dwell
    enable = 1'b0;
    step();
    chk("dis_y", Y, 0); chk("dis_valid", valid, 0);
    enable = 1'b1;
    for (int c = 1; c <= 14; c++) step();   // cycle 14: second cycle of 0x08
    chk("pre_drop_y", Y, 8'h08);
    enable = 1'b0;
    step();
    chk("drop_y", Y, 0); chk("drop_valid", valid, 0); chk("drop_idx", idx, 0);
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("reen_y_c%0d", c), Y, (c <= 4) ? 8'h01 : 8'h02);
    end

    // ---- enable=0 outranks mode=1
    enable = 1'b0;
    step();
    chk("prio_y", Y, 0); chk("prio_valid", valid, 0);
    enable = 1'b1;
    step();
    chk("prio_reentry_y", Y, 8'h01);

    // ---- scan -> decode with load sel=5
    for (int c = 0; c < 6; c++) step();
    mode = 1'b0; load = 1'b1; sel = 3'd5;
    step();
    chk("s2d_load_y", Y, 8'h20); chk("s2d_load_valid", valid, 1); chk("s2d_load_idx", idx, 5);
    load = 1'b0;
    step();
    chk("s2d_hold_y", Y, 8'h20);

    // ---- scan -> decode without load
    mode = 1'b1;
    step();
    chk("rescan_y", Y, 8'h01); chk("rescan_wrap", wrap, 0);
    for (int c = 0; c < 9; c++) step();
    mode = 1'b0;
    step();
    chk("s2d_noload_y", Y, 0); chk("s2d_noload_valid", valid, 0);

    // ---- reset mid-scan, held 2 cycles
    mode = 1'b1;
    for (int c = 0; c < 13; c++) step();
    chk("pre_rst_y", Y, 8'h08);
    reset = 1'b1;
    step();
    chk("mrst_y", Y, 0); chk("mrst_idx", idx, 0); chk("mrst_valid", valid, 0); chk("mrst_wrap", wrap, 0);
    step();
    chk("mrst2_y", Y, 0); chk("mrst2_valid", valid, 0);
    reset = 1'b0;
    step();
    chk("post_rst_y", Y, 8'h01);

    // ---- N=2, DWELL=1: advance every cycle, wrap every 4th
    enable2 = 1'b1; mode2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("d1_y_c%0d", c), Y2, scan2_exp[(c - 1) % 4]);
      chk($sformatf("d1_wrap_c%0d", c), wrap2, (c == 5 || c == 9) ? 1 : 0);
    end

    // ---- random run against a reference model
    reset = 1'b1;
    m_ph = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_wrap = 0; rand_bad = 0;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      load   = $urandom_range(0, 1) == 1;
      sel    = 3'($urandom_range(0, 7));
      if (reset) begin
        m_ph = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
      end else if (!enable) begin
        m_ph = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
      end else if (!mode) begin
        m_wrap = 0; m_cnt = 0;
        if (load) begin m_valid = 1; m_idx = sel; end
        else if (m_ph != 1) begin m_valid = 0; m_idx = 0; end
        m_ph = 1;
      end else if (m_ph != 2) begin
        m_ph = 2; m_idx = 0; m_cnt = 0; m_valid = 1; m_wrap = 0;
      end else if (m_cnt == 3) begin
        m_cnt = 0; m_wrap = (m_idx == 7); m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt++; m_wrap = 0;
      end
      m_y = m_valid ? (8'h01 << m_idx) : 8'h00;
      step();
      if (Y !== m_y || valid !== m_valid || wrap !== m_wrap ||
          (m_valid && idx !== 3'(m_idx)) || (valid && Y[idx] !== 1'b1))
        rand_bad++;
    end
    chk("random_model_cycles_bad", rand_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_scan_decoder
